// File: rtl/tcp_tx_stream_gen.sv
// -----------------------------------------------------------------------------
// tcp_tx_stream_gen
//
// Upstream traffic source for the TCP application TX interface of the network
// stack. A run sends cfg_pkt_num packets of cfg_pkt_len bytes on one open
// session. Each packet is requested with a metadata word. The block then waits
// for the stack's status word and re-requests the packet on an error status.
// On an OK status it streams the payload. Every payload word carries 16 copies
// of a 32-bit running word index. The index starts at 0 per run and carries
// across packets.
//
// Ports
//   aclk, areset               clock, asynchronous active-high reset
//   start                      begin a run (sampled only while idle)
//   cfg_session/pkt_len/pkt_num run configuration, latched on accepted start
//   m_axis_tx_metadata_*       {len[15:0], session[15:0]} send request
//   m_axis_tx_data_*           payload stream (keep all ones, last on final word)
//   s_axis_tx_status_*         status word; [63:61] error, 0 = OK
//   busy, done, aborted        run state: busy level, done pulse, sticky abort
//   pkts_sent, bytes_sent,
//   retry_cnt, cycle_cnt       throughput counters, cleared on accepted start
// -----------------------------------------------------------------------------
module tcp_tx_stream_gen #(
  parameter int          DATA_WIDTH  = 512,
  parameter logic [15:0] MAX_RETRIES = 16'hFFFF
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [15:0]             cfg_session,
  input  logic [15:0]             cfg_pkt_len,
  input  logic [31:0]             cfg_pkt_num,
  output logic                    m_axis_tx_metadata_valid,
  input  logic                    m_axis_tx_metadata_ready,
  output logic [31:0]             m_axis_tx_metadata_data,
  output logic                    m_axis_tx_data_valid,
  input  logic                    m_axis_tx_data_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_tx_data_data,
  output logic [DATA_WIDTH/8-1:0] m_axis_tx_data_keep,
  output logic                    m_axis_tx_data_last,
  input  logic                    s_axis_tx_status_valid,
  output logic                    s_axis_tx_status_ready,
  input  logic [63:0]             s_axis_tx_status_data,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [31:0]             pkts_sent,
  output logic [63:0]             bytes_sent,
  output logic [31:0]             retry_cnt,
  output logic [63:0]             cycle_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int REPL   = DATA_WIDTH / 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_META     = 3'd1,
    ST_WAIT_STS = 3'd2,
    ST_DATA     = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

  state_t                  state_q;
  logic [15:0]             session_q;
  logic [15:0]             len_q;
  logic [31:0]             pkt_num_q;
  logic [9:0]              word_left_q;
  logic [31:0]             word_idx_q;
  logic [15:0]             pkt_retry_q;

  logic                    meta_valid_q;
  logic                    data_valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [KEEP_W-1:0]       keep_q;
  logic                    last_q;
  logic                    sts_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    aborted_q;
  logic [31:0]             pkts_sent_q;
  logic [63:0]             bytes_sent_q;
  logic [31:0]             retry_cnt_q;
  logic [63:0]             cycle_cnt_q;

  logic [31:0]             word_idx_d;
  logic [15:0]             pkt_retry_d;
  logic [31:0]             pkts_sent_d;
  logic [2:0]              sts_err_s;
  logic                    sts_unused_s;

  assign word_idx_d   = word_idx_q + 32'd1;
  assign pkt_retry_d  = pkt_retry_q + 16'd1;
  assign pkts_sent_d  = pkts_sent_q + 32'd1;
  assign sts_err_s    = s_axis_tx_status_data[63:61];
  // Session/length echo fields are deliberately not checked.
  assign sts_unused_s = ^s_axis_tx_status_data[60:0];

  // Run control FSM, handshake outputs and throughput counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      session_q    <= 16'd0;
      len_q        <= 16'd0;
      pkt_num_q    <= 32'd0;
      word_left_q  <= 10'd0;
      word_idx_q   <= 32'd0;
      pkt_retry_q  <= 16'd0;
      meta_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      keep_q       <= {KEEP_W{1'b0}};
      last_q       <= 1'b0;
      sts_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      pkts_sent_q  <= 32'd0;
      bytes_sent_q <= 64'd0;
      retry_cnt_q  <= 32'd0;
      cycle_cnt_q  <= 64'd0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE) begin
        cycle_cnt_q <= cycle_cnt_q + 64'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            session_q    <= cfg_session;
            len_q        <= cfg_pkt_len;
            pkt_num_q    <= cfg_pkt_num;
            word_idx_q   <= 32'd0;
            pkt_retry_q  <= 16'd0;
            aborted_q    <= 1'b0;
            pkts_sent_q  <= 32'd0;
            bytes_sent_q <= 64'd0;
            retry_cnt_q  <= 32'd0;
            cycle_cnt_q  <= 64'd0;
            busy_q       <= 1'b1;
            if (cfg_pkt_num == 32'd0) begin
              state_q <= ST_FIN;
            end else begin
              meta_valid_q <= 1'b1;
              state_q      <= ST_META;
            end
          end
        end

        ST_META: begin
          if (m_axis_tx_metadata_ready) begin
            meta_valid_q <= 1'b0;
            sts_ready_q  <= 1'b1;
            state_q      <= ST_WAIT_STS;
          end
        end

        ST_WAIT_STS: begin
          if (s_axis_tx_status_valid) begin
            sts_ready_q <= 1'b0;
            if (sts_err_s == 3'd0) begin
              word_left_q  <= len_q[15:6];
              data_valid_q <= 1'b1;
              data_q       <= {REPL{word_idx_q}};
              keep_q       <= {KEEP_W{1'b1}};
              last_q       <= (len_q[15:6] == 10'd1);
              state_q      <= ST_DATA;
            end else begin
              retry_cnt_q <= retry_cnt_q + 32'd1;
              pkt_retry_q <= pkt_retry_d;
              if (pkt_retry_d == MAX_RETRIES) begin
                aborted_q <= 1'b1;
                state_q   <= ST_FIN;
              end else begin
                // Re-request the same packet straight away.
                meta_valid_q <= 1'b1;
                state_q      <= ST_META;
              end
            end
          end
        end

        ST_DATA: begin
          if (m_axis_tx_data_ready) begin
            word_idx_q <= word_idx_d;
            if (word_left_q == 10'd1) begin
              data_valid_q <= 1'b0;
              last_q       <= 1'b0;
              keep_q       <= {KEEP_W{1'b0}};
              pkts_sent_q  <= pkts_sent_d;
              bytes_sent_q <= bytes_sent_q + {48'd0, len_q};
              pkt_retry_q  <= 16'd0;
              if (pkts_sent_d == pkt_num_q) begin
                state_q <= ST_FIN;
              end else begin
                meta_valid_q <= 1'b1;
                state_q      <= ST_META;
              end
            end else begin
              word_left_q <= word_left_q - 10'd1;
              data_q      <= {REPL{word_idx_d}};
              last_q      <= (word_left_q == 10'd2);
            end
          end
        end

        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          meta_valid_q <= 1'b0;
          data_valid_q <= 1'b0;
          sts_ready_q  <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tx_metadata_valid = meta_valid_q;
  assign m_axis_tx_metadata_data  = {len_q, session_q};
  assign m_axis_tx_data_valid     = data_valid_q;
  assign m_axis_tx_data_data      = data_q;
  assign m_axis_tx_data_keep      = keep_q;
  assign m_axis_tx_data_last      = last_q;
  assign s_axis_tx_status_ready   = sts_ready_q;
  assign busy                     = busy_q;
  assign done                     = done_q;
  assign aborted                  = aborted_q;
  assign pkts_sent                = pkts_sent_q;
  assign bytes_sent               = bytes_sent_q;
  assign retry_cnt                = retry_cnt_q;
  assign cycle_cnt                = cycle_cnt_q;

endmodule

// File: tb/tb_tcp_tx_stream_gen.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for tcp_tx_stream_gen. Stimulus tasks push the expected
// metadata words and payload words into queues. Independent monitors pop and
// compare on every handshake. Inputs change 1 time unit after the rising edge,
// and monitors sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_tcp_tx_stream_gen;

  logic         aclk = 1'b0;
  logic         areset;
  logic         start;
  logic [15:0]  cfg_session;
  logic [15:0]  cfg_pkt_len;
  logic [31:0]  cfg_pkt_num;
  logic         meta_valid;
  logic         meta_ready;
  logic [31:0]  meta_data;
  logic         data_valid;
  logic         data_ready;
  logic [511:0] data_data;
  logic [63:0]  data_keep;
  logic         data_last;
  logic         sts_valid;
  logic         sts_ready;
  logic [63:0]  sts_data;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [31:0]  pkts_sent;
  logic [63:0]  bytes_sent;
  logic [31:0]  retry_cnt;
  logic [63:0]  cycle_cnt;

  always #5 aclk = ~aclk;

  tcp_tx_stream_gen #(.DATA_WIDTH(512), .MAX_RETRIES(16'd3)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .cfg_session(cfg_session), .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num),
    .m_axis_tx_metadata_valid(meta_valid), .m_axis_tx_metadata_ready(meta_ready),
    .m_axis_tx_metadata_data(meta_data),
    .m_axis_tx_data_valid(data_valid), .m_axis_tx_data_ready(data_ready),
    .m_axis_tx_data_data(data_data), .m_axis_tx_data_keep(data_keep),
    .m_axis_tx_data_last(data_last),
    .s_axis_tx_status_valid(sts_valid), .s_axis_tx_status_ready(sts_ready),
    .s_axis_tx_status_data(sts_data),
    .busy(busy), .done(done), .aborted(aborted), .pkts_sent(pkts_sent),
    .bytes_sent(bytes_sent), .retry_cnt(retry_cnt), .cycle_cnt(cycle_cnt)
  );

  typedef struct {
    logic [31:0] idx;
    logic        last;
  } dexp_t;

  logic [31:0] meta_exp_q[$];
  dexp_t       data_exp_q[$];
  logic [2:0]  sts_err_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          data_hs = 0;
  bit          data_tog = 1'b0;
  logic [15:0] cur_len = 16'd0;
  logic [15:0] cur_sess = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Metadata monitor: every accepted request must match the next expected word.
  always @(negedge aclk) begin
    if (!areset && meta_valid && meta_ready) begin
      if (meta_exp_q.size() == 0) begin
        check("meta_extra_req", 64'(meta_exp_q.size()), 64'd1);
      end else begin
        check("meta_word", {32'd0, meta_data}, {32'd0, meta_exp_q.pop_front()});
      end
    end
  end

  // Payload monitor: compares accepted words and checks stability under stall.
  logic [511:0] held_data;
  logic         held_last;
  bit           stalled = 1'b0;
  always @(negedge aclk) begin
    if (areset) begin
      stalled = 1'b0;
    end else if (data_valid) begin
      if (stalled) begin
        check("stall_data_stable", {63'd0, data_data == held_data}, 64'd1);
        check("stall_last_stable", {63'd0, data_last}, {63'd0, held_last});
      end
      if (data_ready) begin
        stalled = 1'b0;
        data_hs++;
        if (data_exp_q.size() == 0) begin
          check("data_extra_word", 64'(data_exp_q.size()), 64'd1);
        end else begin
          dexp_t e;
          logic [511:0] w;
          e = data_exp_q.pop_front();
          w = {16{e.idx}};
          check("data_index", {32'd0, data_data[31:0]}, {32'd0, e.idx});
          check("data_word", {63'd0, data_data == w}, 64'd1);
          check("data_last", {63'd0, data_last}, {63'd0, e.last});
          check("data_keep", data_keep, 64'hFFFF_FFFF_FFFF_FFFF);
        end
      end else begin
        stalled   = 1'b1;
        held_data = data_data;
        held_last = data_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Status responder: presents the head of the error-code queue as a status word.
  initial begin
    bit hs;
    sts_valid = 1'b0;
    sts_data  = 64'd0;
    forever begin
      @(negedge aclk);
      hs = sts_valid && sts_ready && !areset;
      @(posedge aclk);
      #1;
      if (hs && sts_err_q.size() > 0) void'(sts_err_q.pop_front());
      if (sts_err_q.size() > 0) begin
        sts_valid = 1'b1;
        sts_data  = {sts_err_q[0], 29'd0, cur_len, cur_sess};
      end else begin
        sts_valid = 1'b0;
        sts_data  = 64'd0;
      end
    end
  end

  // Payload ready: always high, or toggling every cycle for backpressure.
  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      data_ready = data_tog ? ~data_ready : 1'b1;
    end
  end

  // Queue the expected traffic of one packet: n_meta requests, the last one OK.
  task automatic expect_pkt(input logic [15:0] sess, input logic [15:0] len,
                            input int n_meta, inout logic [31:0] idx);
    int nw;
    for (int i = 0; i < n_meta; i++) begin
      meta_exp_q.push_back({len, sess});
      sts_err_q.push_back((i == n_meta - 1) ? 3'd0 : 3'd1);
    end
    nw = int'(len) / 64;
    for (int w = 0; w < nw; w++) begin
      dexp_t e;
      e.idx  = idx;
      e.last = (w == nw - 1);
      data_exp_q.push_back(e);
      idx = idx + 32'd1;
    end
  endtask

  task automatic start_run(input logic [15:0] sess, input logic [15:0] len,
                           input logic [31:0] num);
    @(posedge aclk);
    #1;
    cur_sess    = sess;
    cur_len     = len;
    cfg_session = sess;
    cfg_pkt_len = len;
    cfg_pkt_num = num;
    start       = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge aclk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      @(negedge aclk);
      check("done_one_cycle", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic end_checks(input logic [31:0] pkts, input logic [63:0] bytes,
                            input logic [31:0] retries, input logic abrt);
    check("pkts_sent", {32'd0, pkts_sent}, {32'd0, pkts});
    check("bytes_sent", bytes_sent, bytes);
    check("retry_cnt", {32'd0, retry_cnt}, {32'd0, retries});
    check("aborted", {63'd0, aborted}, {63'd0, abrt});
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("meta_all_seen", 64'(meta_exp_q.size()), 64'd0);
    check("data_all_seen", 64'(data_exp_q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_meta_valid"}, {63'd0, meta_valid}, 64'd0);
    check({tag, "_data_valid"}, {63'd0, data_valid}, 64'd0);
    check({tag, "_last"}, {63'd0, data_last}, 64'd0);
    check({tag, "_keep"}, data_keep, 64'd0);
    check({tag, "_sts_ready"}, {63'd0, sts_ready}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_pkts"}, {32'd0, pkts_sent}, 64'd0);
    check({tag, "_cycles"}, cycle_cnt, 64'd0);
  endtask

  initial begin
    logic [31:0] idx;
    int          base;
    bit          hit;
    areset      = 1'b1;
    start       = 1'b0;
    meta_ready  = 1'b1;
    cfg_session = 16'd0;
    cfg_pkt_len = 16'd0;
    cfg_pkt_num = 32'd0;
    repeat (3) @(negedge aclk);
    check_zero_outputs("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // 1: single packet, always-ready sinks.
    idx = 32'd0;
    expect_pkt(16'd5, 16'd128, 1, idx);
    start_run(16'd5, 16'd128, 32'd1);
    wait_done(50);
    end_checks(32'd1, 64'd128, 32'd0, 1'b0);
    check("t1_cycle_cnt", cycle_cnt, 64'd5);

    // 2: four one-word packets with toggling data ready.
    idx = 32'd0;
    for (int p = 0; p < 4; p++) expect_pkt(16'd6, 16'd64, 1, idx);
    data_tog = 1'b1;
    start_run(16'd6, 16'd64, 32'd4);
    wait_done(200);
    data_tog = 1'b0;
    end_checks(32'd4, 64'd256, 32'd0, 1'b0);

    // 3: two error statuses, then OK.
    idx = 32'd0;
    expect_pkt(16'd11, 16'd192, 3, idx);
    start_run(16'd11, 16'd192, 32'd1);
    wait_done(100);
    end_checks(32'd1, 64'd192, 32'd2, 1'b0);

    // 4: every status errors; MAX_RETRIES = 3 aborts the run.
    for (int i = 0; i < 3; i++) begin
      meta_exp_q.push_back({16'd64, 16'd2});
      sts_err_q.push_back(3'd1);
    end
    start_run(16'd2, 16'd64, 32'd1);
    wait_done(100);
    end_checks(32'd0, 64'd0, 32'd3, 1'b1);

    // 5a: zero packets; done two cycles after start, no metadata.
    start_run(16'd8, 16'd64, 32'd0);
    @(negedge aclk);
    check("n0_done_early", {63'd0, done}, 64'd0);
    check("n0_busy", {63'd0, busy}, 64'd1);
    @(negedge aclk);
    check("n0_done", {63'd0, done}, 64'd1);
    check("n0_aborted_cleared", {63'd0, aborted}, 64'd0);
    check("n0_cycle_cnt", cycle_cnt, 64'd1);
    @(negedge aclk);
    check("n0_done_one_cycle", {63'd0, done}, 64'd0);
    end_checks(32'd0, 64'd0, 32'd0, 1'b0);

    // 5b: start pulsed mid-run with a different configuration.
    idx = 32'd0;
    expect_pkt(16'd7, 16'd128, 1, idx);
    expect_pkt(16'd7, 16'd128, 1, idx);
    start_run(16'd7, 16'd128, 32'd2);
    repeat (2) @(posedge aclk);
    #1;
    cfg_session = 16'hBEEF;
    cfg_pkt_len = 16'd64;
    cfg_pkt_num = 32'd9;
    start       = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    wait_done(100);
    end_checks(32'd2, 64'd256, 32'd0, 1'b0);

    // 6: reset while word 3 of 8 is presented.
    idx = 32'd0;
    expect_pkt(16'd3, 16'd512, 1, idx);
    base = data_hs;
    start_run(16'd3, 16'd512, 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge aclk);
      #1;
      if (data_hs >= base + 2) hit = 1'b1;
    end
    check("t6_reached_word3", {63'd0, hit}, 64'd1);
    check("t6_word3_valid", {63'd0, data_valid}, 64'd1);
    areset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    meta_exp_q.delete();
    data_exp_q.delete();
    sts_err_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    idx = 32'd0;
    expect_pkt(16'd9, 16'd128, 1, idx);
    start_run(16'd9, 16'd128, 32'd1);
    wait_done(50);
    end_checks(32'd1, 64'd128, 32'd0, 1'b0);

    repeat (3) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcp_tx_stream_gen.md
Name: tcp_tx_stream_gen

Overview:
- Upstream traffic source for the network stack's TCP application TX interface.
- Sends a configured number of fixed-length packets on one already-open session, using the same interface the stack exposes: tx_metadata, tx_data and tx_status.
- Requests a send with metadata, waits for the stack's status, and retries on error. It then streams the payload with a deterministic pattern.
- Exposes throughput counters for perf ILAs and host readout.

Parameters:
- DATA_WIDTH, 512, TX data word width in bits. The byte count per word is DATA_WIDTH/8 = 64.
- MAX_RETRIES, 16'hFFFF, the consecutive status errors allowed for one packet before the block aborts.

Ports:
- aclk  in  1  Single clock domain.
- areset  in  1  Reset. Asynchronous, active-high. Also the only clock/reset in the block.
- start  in  1  Starts a run. Sampled only in IDLE.
- cfg_session  in  16  TCP session ID.
- cfg_pkt_len  in  16  Packet length in bytes. Must be a nonzero multiple of 64 and at most 65472.
- cfg_pkt_num  in  32  Number of packets to send.
- m_axis_tx_metadata_valid/ready/data  out/in/out  1/1/32  data = {len[15:0], session[15:0]}.
- m_axis_tx_data_valid/ready/data/keep/last  out/in/out/out/out  1/1/512/64/1  Payload stream.
- s_axis_tx_status_valid/ready/data  in/out/in  1/1/64  Status word. [15:0] session, [31:16] length, [63:61] error (0 = OK).
- busy  out  1  High whenever the FSM is not in IDLE.
- done  out  1  One-cycle pulse at the end of a run.
- aborted  out  1  Sticky. Cleared on the next accepted start.
- pkts_sent  out  32  Completed packets.
- bytes_sent  out  64  Sum of completed packet lengths.
- retry_cnt  out  32  Total status errors.
- cycle_cnt  out  64  Cycles spent busy.

Behaviour:
- Reset (asynchronous, areset=1):
  - FSM goes to IDLE and all outputs go to 0, including every valid, last, ready, counter and flag. keep is also 0.
  - Asserting reset mid-run drops valids immediately. No partial packet is completed.
- Configuration latch: cfg_* values are latched on an accepted start (IDLE & start). They are ignored at all other times.
- FSM states: IDLE, META, WAIT_STS, DATA, FIN.
- IDLE:
  - On start: latch cfg, clear all counters and aborted, then go to META.
  - If cfg_pkt_num == 0, go directly to FIN instead.
- META:
  - metadata_valid=1 with {len, session}.
  - Data is held stable until ready. On the handshake, go to WAIT_STS.
- WAIT_STS:
  - tx_status_ready=1 only in this state.
  - On status valid with error == 0: load word_left = len/64 and go to DATA.
  - On status valid with error != 0: retry_cnt++ and per-packet retry counter ++.
    - If the per-packet counter reaches MAX_RETRIES, set aborted and go to FIN.
    - Otherwise go back to META. The same packet is re-requested the next cycle, with no added delay.
  - Session/length fields in the status word are not checked.
- DATA:
  - tx_data_valid=1 and keep = all ones.
  - data = 16 copies of the 32-bit running word index. The index starts at 0 per run and increments on each data handshake. It carries across packets and wraps modulo 2^32.
  - last=1 when word_left == 1.
  - Data, keep and last are held stable while valid & !ready.
  - On the last handshake:
    - pkts_sent++ and bytes_sent += len (zero-extended).
    - The per-packet retry counter clears.
    - If pkts_sent (pre-increment) + 1 == pkt_num, go to FIN. Otherwise go to META.
- FIN: done=1 for exactly one cycle, then IDLE.
- Counter timing:
  - cycle_cnt increments every cycle busy=1, including FIN.
  - All counters hold their value in IDLE until the next accepted start.
- Handshake rules: a valid never deasserts without a handshake, except on reset. Ready never depends on the block's own valid.
- Latencies:
  - Start to metadata_valid: 1 cycle.
  - Status OK to first data valid: 1 cycle.
  - Last data handshake to next metadata_valid: 1 cycle.
- Start while busy: ignored. It has no effect on the latched configuration.

Test Plan:
1. Single packet, always-ready sinks.
   - Stimulus: pkt_len=128, pkt_num=1, session=5, status OK.
   - Required: metadata data=0x00800005; 2 data words with indices 0 and 1; last on word 2; done pulse; pkts_sent=1; bytes_sent=128; retry_cnt=0.
2. Multi-packet with backpressure.
   - Stimulus: pkt_len=64, pkt_num=4, tx_data ready toggled every other cycle.
   - Required: data held stable while stalled; word indices 0..3; every word has last=1; pkts_sent=4; bytes_sent=256.
3. Retry.
   - Stimulus: first two statuses carry error=1, third is OK.
   - Required: metadata issued 3 times; retry_cnt=2; payload sent once; aborted=0.
4. Abort.
   - Stimulus: MAX_RETRIES=3, all statuses carry error=1.
   - Required: 3 metadata requests, then FIN; aborted=1; done pulse; pkts_sent=0.
5. Edge cases.
   - Stimulus: pkt_num=0; and separately, start pulsed while busy.
   - Required for pkt_num=0: done 2 cycles after start, no metadata issued.
   - Required for start while busy: configuration and counters unaffected.
6. Reset mid-DATA.
   - Stimulus: assert areset on word 3 of 8.
   - Required: all valids and counters at 0 in the same cycle; after release, a new start sends from index 0.
